// File: rtl/event_pkt_pkg.sv
// Shared event codes, packet field layout and packet builder for the event packetizer.
package event_pkt_pkg;

    typedef enum logic [1:0] {
        NONE    = 2'b00,
        CLASS_A = 2'b01,
        CLASS_B = 2'b10,
        TIMEOUT = 2'b11
    } event_code_e;

    localparam int PKT_W    = 8;
    localparam int CODE_W   = 2;
    localparam int SEQ_W    = 3;
    localparam int UNIT_W   = 3;
    localparam int CODE_LSB = 6;
    localparam int SEQ_LSB  = 3;
    localparam int UNIT_LSB = 0;

    function automatic logic [PKT_W-1:0] make_pkt(
        input logic [CODE_W-1:0] code,
        input logic [SEQ_W-1:0]  seq,
        input logic [UNIT_W-1:0] unit
    );
        logic [PKT_W-1:0] p;
        p = '0;
        p[CODE_LSB +: CODE_W] = code;
        p[SEQ_LSB +: SEQ_W]   = seq;
        p[UNIT_LSB +: UNIT_W] = unit;
        return p;
    endfunction

endpackage

// File: rtl/pkt_fifo.sv
// Packet FIFO with registered head-of-queue output; a push into an empty (or
// draining-to-empty) queue is forwarded so it appears on the very next edge.
module pkt_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] data,
    output logic             valid,
    output logic             full,
    output logic             empty
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr_reg, wr_ptr_next;
    logic [AW-1:0]    rd_ptr_reg, rd_ptr_next;
    logic [AW:0]      count_reg, count_next;
    logic [WIDTH-1:0] data_reg, data_next;
    logic             valid_reg;
    logic             do_push, do_pop;

    assign empty   = (count_reg == '0);
    assign full    = (count_reg == (AW+1)'(DEPTH));
    assign do_pop  = pop & ~empty;
    assign do_push = push & (~full | do_pop);

    always_comb begin
        rd_ptr_next = rd_ptr_reg + AW'(do_pop);
        wr_ptr_next = wr_ptr_reg + AW'(do_push);
        count_next  = count_reg + (AW+1)'(do_push) - (AW+1)'(do_pop);
        data_next   = '0;
        if (count_next != '0) begin
            // The slot being written this edge is the new head only when the queue was
            // empty or holds a single entry that is popping.
            if (do_push && (wr_ptr_reg == rd_ptr_next)) begin
                data_next = push_data;
            end else begin
                data_next = mem[rd_ptr_next];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr_reg] <= push_data;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
            data_reg   <= '0;
            valid_reg  <= 1'b0;
        end else begin
            wr_ptr_reg <= wr_ptr_next;
            rd_ptr_reg <= rd_ptr_next;
            count_reg  <= count_next;
            data_reg   <= data_next;
            valid_reg  <= (count_next != '0);
        end
    end

    assign data  = data_reg;
    assign valid = valid_reg;

endmodule

// File: rtl/event_packetizer.sv
// Collects per-unit event codes, arbitrates round-robin and emits {code,seq,unit} packets.
// Define EVENT_PACKETIZER_DROP_CNT_EN to add the saturating drop_count output.
module event_packetizer
    import event_pkt_pkg::*;
#(
    parameter int NUM_UNITS  = 8,
    parameter int FIFO_DEPTH = 8
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [2*NUM_UNITS-1:0] event_in_array,
    input  logic                   pkt_ready,
    output logic [7:0]             pkt_data,
    output logic                   pkt_valid,
    output logic                   overflow
`ifdef EVENT_PACKETIZER_DROP_CNT_EN
    ,
    output logic [15:0]            drop_count
`endif
);

    logic [NUM_UNITS-1:0]   pending_reg, pending_next;
    logic [NUM_UNITS-1:0]   loss;
    logic [2*NUM_UNITS-1:0] code_reg, code_next;
    logic [UNIT_W-1:0]      rr_ptr_reg;
    logic [UNIT_W-1:0]      grant_idx;
    logic                   grant_valid;
    logic [UNIT_W:0]        search_idx;
    logic [SEQ_W-1:0]       seq_reg;
    logic                   overflow_reg;
    logic                   fifo_full, fifo_empty;
    logic                   pop, can_grant;
    logic [PKT_W-1:0]       grant_pkt;

    assign pop       = pkt_ready & ~fifo_empty;
    assign can_grant = ~fifo_full | pop;

    // Round-robin search starting at the unit after the last grant.
    always_comb begin
        grant_valid = 1'b0;
        grant_idx   = '0;
        search_idx  = '0;
        for (int i = 0; i < NUM_UNITS; i++) begin
            search_idx = {1'b0, rr_ptr_reg} + (UNIT_W+1)'(i);
            if (search_idx >= (UNIT_W+1)'(NUM_UNITS)) begin
                search_idx = search_idx - (UNIT_W+1)'(NUM_UNITS);
            end
            if (can_grant && !grant_valid && pending_reg[search_idx[UNIT_W-1:0]]) begin
                grant_valid = 1'b1;
                grant_idx   = search_idx[UNIT_W-1:0];
            end
        end
    end

    assign grant_pkt = make_pkt(code_reg[{grant_idx, 1'b0} +: CODE_W], seq_reg, grant_idx);

    // A fresh code always wins; it only counts as a loss if it displaces one that
    // was not leaving on this same edge.
    genvar gi;
    generate
        for (gi = 0; gi < NUM_UNITS; gi++) begin : g_unit
            logic [1:0] ev;
            logic       granted;
            assign ev      = event_in_array[2*gi +: 2];
            assign granted = grant_valid && (grant_idx == UNIT_W'(gi));
            assign loss[gi]         = (ev != NONE) && pending_reg[gi] && !granted;
            assign pending_next[gi] = (ev != NONE) || (pending_reg[gi] && !granted);
            assign code_next[2*gi +: 2] = (ev != NONE) ? ev : code_reg[2*gi +: 2];
        end
    endgenerate

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pending_reg  <= '0;
            code_reg     <= '0;
            rr_ptr_reg   <= '0;
            seq_reg      <= '0;
            overflow_reg <= 1'b0;
        end else begin
            pending_reg  <= pending_next;
            code_reg     <= code_next;
            overflow_reg <= overflow_reg | (|loss);
            if (grant_valid) begin
                seq_reg    <= seq_reg + SEQ_W'(1);
                rr_ptr_reg <= (grant_idx == UNIT_W'(NUM_UNITS-1)) ? '0 : grant_idx + UNIT_W'(1);
            end
        end
    end

    assign overflow = overflow_reg;

`ifdef EVENT_PACKETIZER_DROP_CNT_EN
    logic [UNIT_W:0] loss_cnt;
    logic [16:0]     drop_sum;
    logic [15:0]     drop_count_reg;

    always_comb begin
        loss_cnt = '0;
        for (int i = 0; i < NUM_UNITS; i++) begin
            loss_cnt = loss_cnt + (UNIT_W+1)'(loss[i]);
        end
        drop_sum = {1'b0, drop_count_reg} + 17'(loss_cnt);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            drop_count_reg <= '0;
        end else begin
            drop_count_reg <= drop_sum[16] ? 16'hFFFF : drop_sum[15:0];
        end
    end

    assign drop_count = drop_count_reg;
`endif

    pkt_fifo #(
        .WIDTH(PKT_W),
        .DEPTH(FIFO_DEPTH)
    ) u_fifo (
        .clk      (clk),
        .rst      (rst),
        .push     (grant_valid),
        .push_data(grant_pkt),
        .pop      (pop),
        .data     (pkt_data),
        .valid    (pkt_valid),
        .full     (fifo_full),
        .empty    (fifo_empty)
    );

endmodule

// File: tb/tb_event_packetizer.sv
// Bench for event_packetizer: directed scenarios plus random traffic against a queue-based model.
module tb_event_packetizer;

    localparam int N = 8;
    localparam int D = 8;

    logic           clk = 1'b0;
    logic           rst = 1'b0;
    logic [2*N-1:0] event_in_array = '0;
    logic           pkt_ready = 1'b0;
    logic [7:0]     pkt_data;
    logic           pkt_valid;
    logic           overflow;
`ifdef EVENT_PACKETIZER_DROP_CNT_EN
    logic [15:0]    drop_count;
`endif

    always #5 clk = ~clk;

    event_packetizer #(.NUM_UNITS(N), .FIFO_DEPTH(D)) dut (
        .clk           (clk),
        .rst           (rst),
        .event_in_array(event_in_array),
        .pkt_ready     (pkt_ready),
        .pkt_data      (pkt_data),
        .pkt_valid     (pkt_valid),
        .overflow      (overflow)
`ifdef EVENT_PACKETIZER_DROP_CNT_EN
        ,
        .drop_count    (drop_count)
`endif
    );

    int n_checks = 0;
    int n_pass   = 0;

    // Reference model state
    logic [7:0] mq[$];
    logic       m_pend[N];
    logic [1:0] m_code[N];
    int         m_rr;
    int         m_seq;
    logic       m_ovf;
    int         m_drop;
    logic [7:0] seen[$];

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    function automatic logic [2*N-1:0] ev_unit(input int u, input logic [1:0] c);
        logic [2*N-1:0] v;
        v = '0;
        v[2*u +: 2] = c;
        return v;
    endfunction

    task automatic model_reset();
        mq.delete();
        for (int u = 0; u < N; u++) begin
            m_pend[u] = 1'b0;
            m_code[u] = 2'b00;
        end
        m_rr   = 0;
        m_seq  = 0;
        m_ovf  = 1'b0;
        m_drop = 0;
    endtask

    // One clock of the abstract behaviour: pop, round-robin pick, latch new events.
    task automatic model_step(input logic [2*N-1:0] ev, input logic rdy);
        bit popping;
        int gnt;
        int losses;
        logic [1:0] c;
        popping = (mq.size() > 0) && rdy;
        gnt = -1;
        if (mq.size() < D || popping) begin
            for (int k = 0; k < N; k++) begin
                if (gnt < 0 && m_pend[(m_rr + k) % N]) gnt = (m_rr + k) % N;
            end
        end
        if (popping) void'(mq.pop_front());
        if (gnt >= 0) begin
            mq.push_back({m_code[gnt], 3'(m_seq), 3'(gnt)});
            m_seq = (m_seq + 1) % 8;
            m_rr  = (gnt + 1) % N;
        end
        losses = 0;
        for (int u = 0; u < N; u++) begin
            c = ev[2*u +: 2];
            if (c != 2'b00) begin
                if (m_pend[u] && u != gnt) losses++;
                m_pend[u] = 1'b1;
                m_code[u] = c;
            end else if (u == gnt) begin
                m_pend[u] = 1'b0;
            end
        end
        if (losses > 0) m_ovf = 1'b1;
        m_drop = (m_drop + losses > 65535) ? 65535 : m_drop + losses;
    endtask

    task automatic check_cycle();
        check_val("valid", 32'(pkt_valid), 32'(mq.size() != 0));
        if (mq.size() != 0) check_val("data", 32'(pkt_data), 32'(mq[0]));
        check_val("overflow", 32'(overflow), 32'(m_ovf));
`ifdef EVENT_PACKETIZER_DROP_CNT_EN
        check_val("drop_count", 32'(drop_count), 32'(m_drop));
`endif
    endtask

    task automatic step(input logic [2*N-1:0] ev, input logic rdy);
        event_in_array = ev;
        pkt_ready      = rdy;
        if (pkt_valid && rdy) begin
            seen.push_back(pkt_data);
            $display("pkt %02h accepted at %0t", pkt_data, $time);
        end
        model_step(ev, rdy);
        @(posedge clk);
        #1;
        check_cycle();
    endtask

    task automatic do_reset();
        event_in_array = '0;
        pkt_ready      = 1'b0;
        rst            = 1'b1;
        model_reset();
        seen.delete();
        #1;
        check_val("rst_valid", 32'(pkt_valid), 32'd0);
        check_val("rst_data", 32'(pkt_data), 32'h00);
        check_val("rst_overflow", 32'(overflow), 32'd0);
`ifdef EVENT_PACKETIZER_DROP_CNT_EN
        check_val("rst_drop", 32'(drop_count), 32'd0);
`endif
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    task automatic drain(input int want, input int budget);
        for (int i = 0; i < budget && seen.size() < want; i++) step('0, 1'b1);
        check_val("drain_count", 32'(seen.size()), 32'(want));
    endtask

    initial begin
        logic [2*N-1:0] v;
        logic           r;

        #2;
        do_reset();

        // Single event, unit 3 class A
        step(ev_unit(3, 2'b01), 1'b1);
        step('0, 1'b1);
        check_val("s1_valid", 32'(pkt_valid), 32'd1);
        check_val("s1_data", 32'(pkt_data), 32'h43);
        step('0, 1'b1);
        check_val("s1_once", 32'(pkt_valid), 32'd0);

        // Simultaneous events on units 0, 2, 5
        do_reset();
        step(ev_unit(0, 2'b10) | ev_unit(2, 2'b10) | ev_unit(5, 2'b10), 1'b1);
        drain(3, 10);
        if (seen.size() >= 3) begin
            check_val("s2_first", 32'(seen[0]), 32'h80);
            check_val("s2_second", 32'(seen[1]), 32'h8A);
            check_val("s2_third", 32'(seen[2]), 32'h95);
        end

        // Backpressure: 9 events, 8 fit, then drain with seq wrap
        do_reset();
        for (int u = 0; u < N; u++) step(ev_unit(u, 2'b01), 1'b0);
        step(ev_unit(0, 2'b11), 1'b0);
        for (int i = 0; i < 4; i++) begin
            step('0, 1'b0);
            check_val("s3_hold", 32'(pkt_data), 32'h40);
        end
        drain(9, 30);
        if (seen.size() >= 9) begin
            check_val("s3_eighth", 32'(seen[7]), 32'h7F);
            check_val("s3_wrap", 32'(seen[8]), 32'hC0);
        end

        // Overwrite while FIFO full
        do_reset();
        for (int u = 0; u < N; u++) step(ev_unit(u, 2'b10), 1'b0);
        repeat (3) step('0, 1'b0);
        step(ev_unit(1, 2'b01), 1'b0);
        step(ev_unit(1, 2'b11), 1'b0);
        check_val("s4_overflow", 32'(overflow), 32'd1);
`ifdef EVENT_PACKETIZER_DROP_CNT_EN
        check_val("s4_drop", 32'(drop_count), 32'd1);
`endif
        drain(9, 30);
        if (seen.size() >= 9) check_val("s4_last", 32'(seen[8]), 32'hC1);

        // Reset mid-operation with 4 packets queued and overflow set
        do_reset();
        step(ev_unit(0, 2'b01) | ev_unit(1, 2'b01), 1'b0);
        step(ev_unit(1, 2'b10) | ev_unit(2, 2'b01) | ev_unit(3, 2'b01), 1'b0);
        repeat (4) step('0, 1'b0);
        check_val("s5_overflow_pre", 32'(overflow), 32'd1);
        #2;
        rst = 1'b1;
        model_reset();
        seen.delete();
        #1;
        check_val("s5_valid_async", 32'(pkt_valid), 32'd0);
        check_val("s5_overflow_async", 32'(overflow), 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        repeat (3) step('0, 1'b1);
        step(ev_unit(6, 2'b01), 1'b1);
        step('0, 1'b1);
        check_val("s5_seq_restart", 32'(pkt_data), 32'h46);

        // Random traffic, heavy backpressure then light
        do_reset();
        for (int cyc = 0; cyc < 800; cyc++) begin
            v = '0;
            for (int u = 0; u < N; u++) begin
                if ($urandom_range(0, 3) == 0) v[2*u +: 2] = 2'($urandom_range(1, 3));
            end
            if (cyc < 400) r = ($urandom_range(0, 3) == 0);
            else           r = ($urandom_range(0, 3) != 0);
            step(v, r);
        end
        drain(seen.size() + mq.size(), 40);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/event_packetizer.md
EVENT_PACKETIZER -- requirements
Module: event_packetizer

Interface
REQ-001 SHALL have parameter NUM_UNITS, default 8, giving the number of processing units served (1..8).
REQ-002 SHALL have parameter FIFO_DEPTH, default 8, giving the packet FIFO depth (power of 2, >=2).
REQ-003 SHALL have port clk  input  1  sole clock, rising edge.
REQ-004 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-005 SHALL have port event_in_array  input  2*NUM_UNITS  per-unit event code; bits [2u+1:2u] belong to unit u.
REQ-006 SHALL have port pkt_ready  input  1  downstream accepts pkt_data this cycle.
REQ-007 SHALL have port pkt_data  output  8  packet byte {code[1:0], seq[2:0], unit[2:0]}.
REQ-008 SHALL have port pkt_valid  output  1  pkt_data holds a valid packet.
REQ-009 SHALL have port overflow  output  1  sticky flag: at least one event lost.

Function
REQ-010 SHALL treat code 2'b00 as no event; 01 class A, 10 class B, 11 timeout are all events.
REQ-011 SHALL sample event_in_array every rising edge; a nonzero code sets pending[u] and stores code[u].
REQ-012 SHALL overwrite code[u] with a new nonzero code when pending[u] is already set and not dequeued that cycle; the overwritten event counts as a loss.
REQ-013 SHALL, when unit u is granted and a new nonzero code arrives on the same edge, keep pending[u] set with the new code; this is not a loss.
REQ-014 SHALL grant at most one pending unit per cycle via round-robin, starting search at last-granted+1, wrapping NUM_UNITS-1 -> 0; after reset search starts at unit 0.
REQ-015 SHALL grant only when the FIFO is not full, or full with a pop in the same cycle.
REQ-016 SHALL, on grant, write {code[u], seq, u} into the FIFO, clear pending[u], increment seq modulo 8 (7 -> 0 wrap).
REQ-017 SHALL have latency of exactly 2 edges from event sample to pkt_valid with idle FIFO and no contention.
REQ-018 SHALL present packets in FIFO order; pkt_data and pkt_valid stay stable while pkt_valid=1 and pkt_ready=0.
REQ-019 SHALL pop on pkt_valid & pkt_ready; pkt_ready while pkt_valid=0 has no effect.
REQ-020 SHALL set overflow on any loss per REQ-012; it stays set until reset.

Reset
REQ-021 SHALL on rst clear pending, codes, seq, arbiter pointer, FIFO pointers and overflow; pkt_valid=0, pkt_data=8'h00.
REQ-022 SHALL discard all queued and pending events when rst asserts mid-operation; nothing emitted after release until new events.

Configuration
REQ-023 SHALL, with EVENT_PACKETIZER_DROP_CNT_EN defined, add output drop_count (16 bits), incremented per loss, saturating at 16'hFFFF, cleared by rst.
REQ-024 SHALL, without EVENT_PACKETIZER_DROP_CNT_EN, omit drop_count port and logic entirely; all other behaviour unchanged.

Structure
REQ-025 SHALL take event code constants (NONE, CLASS_A, CLASS_B, TIMEOUT) and packet field widths/offsets from shared package event_pkt_pkg.
REQ-026 SHALL implement the FIFO as sub-module pkt_fifo (synchronous, registered output, full/empty flags).

Verification
REQ-027 SHALL cover: unit 3 code 01 one cycle, pkt_ready=1 -> after 2 edges pkt_data=8'h43, pkt_valid one cycle.
REQ-028 SHALL cover: units 0,2,5 code 10 same cycle -> packets 8'h80, 8'h8A, 8'h95 in that order (seq 0,1,2).
REQ-029 SHALL cover: pkt_ready=0, 9 distinct events on 8 units over time -> 8 packets queued, pkt_data stable, later events pending; release ready -> all drained in order, seq wraps 7->0.
REQ-030 SHALL cover: unit 1 code 01 then code 11 next cycle while FIFO full -> one packet with code 11, overflow=1, drop_count=1 (macro on).
REQ-031 SHALL cover: rst asserted with 4 packets queued -> pkt_valid=0 immediately, overflow=0, seq restarts at 0.
